fetch_seq_ctrl: RTL
===================

// Module: fetch_seq_ctrl
// PURPOSE
//  Sequences instruction fetch against a variable-latency instruction memory (req/ack).
//  Drives the fetch stage's PC hold (pc_ena_h_o, 1 = hold) and F/D flush (fd_clr_h_o).
//  Buffers a returned word while decode is stalled, and discards stale responses after a redirect.
//  Sits between the PC register, the IMEM port and the hazard unit.
// PARAMETERS
//  ADDR_W       32  IMEM address width (PC bits forwarded to imem_addr_o)
//  TIMEOUT_CYC  15  max WAIT cycles before a timeout (FETCH_TIMEOUT_EN builds only)
//  CNT_W        16  width of the stall-cycle counter
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       asynchronous reset, active-low
//  pc_i         in   ADDR_W  current PC from the PC register
//  redirect_i   in   1       taken branch/jump resolved in EX (PC_SRC != 0)
//  stall_ext_i  in   1       load-use stall from the hazard unit
//  imem_req_o   out  1       fetch request; imem_addr_o is valid while this is high
//  imem_addr_o  out  ADDR_W  fetch address (= pc_i)
//  imem_ack_i   in   1       1-cycle pulse: request complete, imem_rdata_i valid
//  imem_rdata_i in   32      instruction word
//  instr_o      out  32      instruction to the F/D register
//  pc_ena_h_o   out  1       1 = hold PC and F/D register; 0 = advance/load
//  fd_clr_h_o   out  1       1 = clear F/D register on the next edge
//  stall_cnt_o  out  CNT_W   saturating count of cycles with pc_ena_h_o=1 (state != IDLE)
//  err_o        out  1       sticky fetch timeout (0 when the macro is not defined)
// BEHAVIOUR
//  Reset: state=IDLE; buffer=0; stall_cnt_o=0; err_o=0.
//   In IDLE: imem_req_o=0, pc_ena_h_o=1, fd_clr_h_o=0, instr_o=0.
//  States: IDLE=2'b00, WAIT=2'b01, KILL=2'b10, HOLD=2'b11. Outputs are combinational from state/inputs.
//  IDLE: unconditionally goes to WAIT on the first clock after reset release.
//  WAIT: imem_req_o=1, imem_addr_o=pc_i. At most one request is outstanding.
//   - No ack, no redirect: pc_ena_h_o=1; stay in WAIT.
//   - redirect_i (no ack): pc_ena_h_o=0 (PC loads the target); fd_clr_h_o=1; go to KILL.
//   - ack & redirect_i: drop the word; pc_ena_h_o=0; fd_clr_h_o=1; stay in WAIT.
//   - ack & stall_ext_i: capture imem_rdata_i into the buffer; pc_ena_h_o=1; go to HOLD.
//   - ack only: instr_o=imem_rdata_i (same cycle, zero added latency); pc_ena_h_o=0; stay in WAIT.
//     The next request uses the new PC on the following cycle.
//  KILL: imem_req_o=0; pc_ena_h_o=1; waits for the stale ack and discards it, then goes to WAIT.
//   - redirect_i in KILL: pc_ena_h_o=0; fd_clr_h_o=1; stay in KILL (the stale request is still pending).
//   - A stale ack and a new redirect in the same cycle: the ack is consumed; load the target; go to WAIT.
//  HOLD: imem_req_o=0; instr_o=buffer.
//   - stall_ext_i=1: pc_ena_h_o=1.
//   - stall drops: pc_ena_h_o=0 (deliver); go to WAIT.
//   - redirect_i: drop the buffer; pc_ena_h_o=0; fd_clr_h_o=1; go to WAIT.
//  Priority: redirect_i > stall_ext_i > imem_ack_i.
//   fd_clr_h_o=1 on every cycle in which redirect_i=1 (any state except IDLE).
//  An ack in IDLE or HOLD is a protocol error: it is ignored and does not change state.
//  stall_cnt_o: increments each cycle with pc_ena_h_o=1 and state!=IDLE; saturates at all-ones.
//  Reset asserted mid-transaction: return to IDLE at once. Any late ack after release is ignored
//   until WAIT is entered; the memory must also be reset.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   - A WAIT-cycle counter clears on ack, on redirect and on state entry.
//   - When it reaches TIMEOUT_CYC: err_o is set (sticky until reset).
//   - In that cycle, NOP 32'h0000_0013 is delivered (pc_ena_h_o=0) and the FSM goes to KILL.
//  FETCH_TIMEOUT_EN undefined: no counter; err_o tied to 0; WAIT may last indefinitely.
// TESTING
//  1 Reset release, ack 1 cycle after every request, pc_i=0,4,8.
//    -> instr_o follows rdata each ack; pc_ena_h_o=0 on ack cycles only.
//  2 Ack with rdata=32'h00A00093 and stall_ext_i=1 for 3 cycles.
//    -> HOLD; instr_o stable at 32'h00A00093; pc_ena_h_o=1 for 3 cycles; delivered on cycle 4.
//  3 redirect_i pulse 2 cycles into WAIT, ack 3 cycles later (rdata=32'hDEADBEEF).
//    -> fd_clr_h_o=1 for 1 cycle; the word is never on instr_o; next request uses the target PC.
//  4 ack, redirect_i and stall_ext_i all high in the same cycle.
//    -> word dropped; fd_clr_h_o=1; pc_ena_h_o=0; state stays WAIT.
//  5 rst_i low during KILL, then release.
//    -> IDLE outputs immediately; stall_cnt_o=0; a stray ack before WAIT is ignored.
//  6 FETCH_TIMEOUT_EN, TIMEOUT_CYC=15, no ack.
//    -> err_o=1 after 15 WAIT cycles; instr_o=32'h00000013 that cycle; state becomes KILL.

Source files
------------

// File: rtl/fetch_seq_ctrl_if.sv
// Instruction-memory request/ack port between the fetch sequencer and the IMEM.
// master = fetch sequencer side, slave = memory side.
interface fetch_seq_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: one outstanding IMEM request, stall buffering, stale-response discard.
// Optional build macro FETCH_TIMEOUT_EN adds a WAIT watchdog driving the sticky err_o.
module fetch_seq_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               redirect_i,
  input  logic               stall_ext_i,
  fetch_seq_ctrl_if.master   imem,
  output logic [31:0]        instr_o,
  output logic               pc_ena_h_o,
  output logic               fd_clr_h_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic               err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    KILL = 2'b10,
    HOLD = 2'b11
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t           state_q, state_d;
  logic [31:0]      buf_q, buf_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             req;
  logic             buf_ld;
  logic             timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int          TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
`endif

  // Next-state and combinational outputs; priority redirect > stall > ack.
  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    pc_ena_h_o = 1'b1;
    fd_clr_h_o = 1'b0;
    instr_o    = 32'h0;
    buf_ld     = 1'b0;
    timeout    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = WAIT;
      end

      WAIT: begin
        req = 1'b1;
        if (redirect_i) begin
          pc_ena_h_o = 1'b0;
          fd_clr_h_o = 1'b1;
          if (!imem.imem_ack) begin
            state_d = KILL;
          end
        end else if (imem.imem_ack) begin
          if (stall_ext_i) begin
            buf_ld  = 1'b1;
            state_d = HOLD;
          end else begin
            instr_o    = imem.imem_rdata;
            pc_ena_h_o = 1'b0;
          end
`ifdef FETCH_TIMEOUT_EN
        end else if (wait_cnt_q == TO_LAST) begin
          // Give up on the memory: feed decode a NOP and reap the late ack in KILL.
          timeout    = 1'b1;
          instr_o    = NOP_INSTR;
          pc_ena_h_o = 1'b0;
          state_d    = KILL;
`endif
        end
      end

      KILL: begin
        if (redirect_i) begin
          pc_ena_h_o = 1'b0;
          fd_clr_h_o = 1'b1;
        end
        if (imem.imem_ack) begin
          state_d = WAIT;
        end
      end

      HOLD: begin
        instr_o = buf_q;
        if (redirect_i) begin
          pc_ena_h_o = 1'b0;
          fd_clr_h_o = 1'b1;
          state_d    = WAIT;
        end else if (!stall_ext_i) begin
          pc_ena_h_o = 1'b0;
          state_d    = WAIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_i;

  always_comb begin
    buf_d = buf_q;
    if (buf_ld) begin
      buf_d = imem.imem_rdata;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_ena_h_o && (state_q != IDLE) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      buf_q       <= 32'h0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

`ifdef FETCH_TIMEOUT_EN
  // Counts consecutive ack-less WAIT cycles; anything outside WAIT restarts it.
  always_comb begin
    wait_cnt_d = wait_cnt_q + TO_W'(1);
    if ((state_q != WAIT) || imem.imem_ack || redirect_i || timeout) begin
      wait_cnt_d = '0;
    end
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  // TIMEOUT_CYC is inert here; the comparison is constant false.
  assign err_o = (TIMEOUT_CYC < 0);
`endif

endmodule
